// File: rtl/stepper_ramp_sequencer.sv
// Acceleration-limited speed/direction sequencer in front of one MotorDriver:
// ramped speed changes, reversal sequencing, driver settle delay, watchdog and estop.
module stepper_ramp_sequencer #(
   parameter int SPEED_W         = 10,
   parameter int MAX_SPEED       = 400,
   parameter int RAMP_DIV        = 100000,
   parameter int RAMP_STEP       = 10,
   parameter int SETTLE_CYCLES   = 200000,
   parameter int WATCHDOG_CYCLES = 50000000
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               cmd_valid,
   input  logic [SPEED_W-1:0] cmd_speed,
   input  logic               cmd_dir,
   input  logic               cmd_enable,
   input  logic               estop,
   output logic [SPEED_W-1:0] motor_speed,
   output logic               motor_dir,
   output logic               run_en,
   output logic               at_target,
   output logic               wdog_expired,
   output logic [2:0]         state
);

   localparam int SW1    = SPEED_W + 1;
   localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int SETL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int WDOG_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

   localparam logic [SPEED_W-1:0] SPEED_ZERO = {SPEED_W{1'b0}};
   localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);
   localparam logic [SW1-1:0]     STEP_EXT   = SW1'(RAMP_STEP);

   localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
   localparam logic [SETL_W-1:0] SETL_ZERO = {SETL_W{1'b0}};
   localparam logic [SETL_W-1:0] SETL_ONE  = SETL_W'(1);
   localparam logic [SETL_W-1:0] SETL_LAST = SETL_W'(SETTLE_CYCLES - 1);
   localparam logic [WDOG_W-1:0] WDOG_ZERO = {WDOG_W{1'b0}};
   localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WATCHDOG_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_RUN       = 3'd2,
      ST_DECEL_REV = 3'd3,
      ST_REV_HOLD  = 3'd4,
      ST_STOP      = 3'd5
   } state_t;

   state_t               state_r;
   logic [SPEED_W-1:0]   motor_speed_r;
   logic                 motor_dir_r;
   logic                 run_en_r;
   logic                 at_target_r;
   logic                 wdog_expired_r;
   logic [SPEED_W-1:0]   tgt_speed_r;
   logic                 tgt_dir_r;
   logic                 tgt_en_r;
   logic [TICK_W-1:0]    tick_cnt_r;
   logic [SETL_W-1:0]    settle_cnt_r;
   logic [WDOG_W-1:0]    wdog_cnt_r;

   logic                 tick_s;
   logic [SPEED_W-1:0]   goal_s;
   logic [SPEED_W-1:0]   ramp_s;
   logic [SPEED_W-1:0]   clamp_s;

   // One ramp step from cur toward goal, widened by one bit so neither direction can wrap.
   function automatic logic [SPEED_W-1:0] ramp_f(input logic [SPEED_W-1:0] cur,
                                                 input logic [SPEED_W-1:0] goal);
      logic [SW1-1:0] cur_s;
      logic [SW1-1:0] goal_ext_s;
      logic [SW1-1:0] up_s;
      logic [SW1-1:0] dn_s;
      cur_s      = {1'b0, cur};
      goal_ext_s = {1'b0, goal};
      up_s       = cur_s + STEP_EXT;
      dn_s       = cur_s - STEP_EXT;
      if (cur_s < goal_ext_s) begin
         if (up_s > goal_ext_s) begin
            ramp_f = goal;
         end else begin
            ramp_f = up_s[SPEED_W-1:0];
         end
      end else if (cur_s > goal_ext_s) begin
         if ((cur_s - goal_ext_s) > STEP_EXT) begin
            ramp_f = dn_s[SPEED_W-1:0];
         end else begin
            ramp_f = goal;
         end
      end else begin
         ramp_f = goal;
      end
   endfunction

   // Ramp goal of the current state; only RUN aims above zero.
   always_comb begin
      goal_s = SPEED_ZERO;
      case (state_r)
         ST_RUN:  goal_s = tgt_speed_r;
         default: goal_s = SPEED_ZERO;
      endcase
   end

   assign tick_s  = (state_r != ST_IDLE) && (tick_cnt_r == TICK_LAST);
   assign ramp_s  = ramp_f(motor_speed_r, goal_s);
   assign clamp_s = (cmd_speed > SPEED_MAX) ? SPEED_MAX : cmd_speed;

   // Sequencer FSM with command capture, watchdog, ramp tick and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         motor_speed_r  <= SPEED_ZERO;
         motor_dir_r    <= 1'b1;
         run_en_r       <= 1'b0;
         at_target_r    <= 1'b0;
         wdog_expired_r <= 1'b0;
         tgt_speed_r    <= SPEED_ZERO;
         tgt_dir_r      <= 1'b1;
         tgt_en_r       <= 1'b0;
         tick_cnt_r     <= TICK_ZERO;
         settle_cnt_r   <= SETL_ZERO;
         wdog_cnt_r     <= WDOG_ZERO;
      end else if (estop) begin
         state_r       <= ST_IDLE;
         motor_speed_r <= SPEED_ZERO;
         run_en_r      <= 1'b0;
         at_target_r   <= 1'b0;
         tgt_en_r      <= 1'b0;
         tick_cnt_r    <= TICK_ZERO;
         settle_cnt_r  <= SETL_ZERO;
         wdog_cnt_r    <= WDOG_ZERO;
      end else begin
         // A command in the expiry cycle wins: counter cleared, flag not raised.
         if (cmd_valid) begin
            tgt_speed_r    <= clamp_s;
            tgt_dir_r      <= cmd_dir;
            tgt_en_r       <= cmd_enable;
            wdog_cnt_r     <= WDOG_ZERO;
            wdog_expired_r <= 1'b0;
         end else if (state_r == ST_IDLE) begin
            wdog_cnt_r <= WDOG_ZERO;
         end else if (wdog_cnt_r == WDOG_LAST) begin
            wdog_cnt_r     <= WDOG_ZERO;
            wdog_expired_r <= 1'b1;
            tgt_en_r       <= 1'b0;
         end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_ONE;
         end

         // at_target reflects the previous cycle's registered speed/direction/state.
         at_target_r  <= (state_r == ST_RUN) && (motor_speed_r == tgt_speed_r) &&
                         (motor_dir_r == tgt_dir_r);
         tick_cnt_r   <= (tick_s || (state_r == ST_IDLE)) ? TICK_ZERO : (tick_cnt_r + TICK_ONE);
         settle_cnt_r <= SETL_ZERO;
         if (tick_s) begin
            motor_speed_r <= ramp_s;
         end

         case (state_r)
            ST_IDLE: begin
               motor_speed_r <= SPEED_ZERO;
               run_en_r      <= 1'b0;
               if (tgt_en_r) begin
                  state_r     <= ST_SETTLE;
                  tick_cnt_r  <= TICK_ZERO;
                  motor_dir_r <= tgt_dir_r;
                  run_en_r    <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (!tgt_en_r) begin
                  state_r    <= ST_STOP;
                  tick_cnt_r <= TICK_ZERO;
               end else if (settle_cnt_r == SETL_LAST) begin
                  state_r    <= ST_RUN;
                  tick_cnt_r <= TICK_ZERO;
               end else begin
                  settle_cnt_r <= settle_cnt_r + SETL_ONE;
               end
            end
            ST_RUN: begin
               if (!tgt_en_r) begin
                  state_r    <= ST_STOP;
                  tick_cnt_r <= TICK_ZERO;
               end else if (tgt_dir_r != motor_dir_r) begin
                  tick_cnt_r <= TICK_ZERO;
                  if (motor_speed_r != SPEED_ZERO) begin
                     state_r <= ST_DECEL_REV;
                  end else begin
                     // Already stopped: never accelerate in the old direction on the way out.
                     state_r       <= ST_REV_HOLD;
                     motor_speed_r <= SPEED_ZERO;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DECEL_REV: begin
               if (!tgt_en_r) begin
                  state_r    <= ST_STOP;
                  tick_cnt_r <= TICK_ZERO;
               end else if (tgt_dir_r == motor_dir_r) begin
                  state_r    <= ST_RUN;
                  tick_cnt_r <= TICK_ZERO;
               end else if (motor_speed_r == SPEED_ZERO) begin
                  state_r    <= ST_REV_HOLD;
                  tick_cnt_r <= TICK_ZERO;
               end else begin
                  state_r <= ST_DECEL_REV;
               end
            end
            ST_REV_HOLD: begin
               motor_speed_r <= SPEED_ZERO;
               if (!tgt_en_r) begin
                  state_r    <= ST_STOP;
                  tick_cnt_r <= TICK_ZERO;
               end else if (settle_cnt_r == SETL_LAST) begin
                  state_r     <= ST_RUN;
                  tick_cnt_r  <= TICK_ZERO;
                  motor_dir_r <= tgt_dir_r;
               end else begin
                  settle_cnt_r <= settle_cnt_r + SETL_ONE;
               end
            end
            ST_STOP: begin
               if (tgt_en_r) begin
                  state_r    <= ST_RUN;
                  tick_cnt_r <= TICK_ZERO;
               end else if (motor_speed_r == SPEED_ZERO) begin
                  state_r    <= ST_IDLE;
                  tick_cnt_r <= TICK_ZERO;
                  run_en_r   <= 1'b0;
               end else begin
                  state_r <= ST_STOP;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               tick_cnt_r    <= TICK_ZERO;
               motor_speed_r <= SPEED_ZERO;
               run_en_r      <= 1'b0;
            end
         endcase
      end
   end

   assign motor_speed  = motor_speed_r;
   assign motor_dir    = motor_dir_r;
   assign run_en       = run_en_r;
   assign at_target    = at_target_r;
   assign wdog_expired = wdog_expired_r;
   assign state        = state_r;

endmodule

// File: tb/tb_stepper_ramp_sequencer.sv
// Directed scenarios plus randomized commands for stepper_ramp_sequencer, checked
// every cycle against a behavioural model built on time-in-state arithmetic.
module tb_stepper_ramp_sequencer;

   localparam int SPEED_W  = 10;
   localparam int MAXSPD   = 400;
   localparam int DIV      = 4;
   localparam int STEP     = 50;
   localparam int SETTLE   = 8;
   localparam int WDOG     = 2000;

   localparam int S_IDLE = 0, S_SETTLE = 1, S_RUN = 2, S_DECEL = 3, S_HOLD = 4, S_STOP = 5;

   logic               clock = 1'b0;
   logic               reset_n;
   logic               cmd_valid;
   logic [SPEED_W-1:0] cmd_speed;
   logic               cmd_dir;
   logic               cmd_enable;
   logic               estop;
   logic [SPEED_W-1:0] motor_speed;
   logic               motor_dir;
   logic               run_en;
   logic               at_target;
   logic               wdog_expired;
   logic [2:0]         state;

   int checks_total  = 0;
   int checks_passed = 0;
   int checks_failed = 0;

   // model of the sequencer
   int m_state, m_speed, m_dir, m_run, m_at, m_wexp;
   int t_speed, t_dir, t_en;
   int in_state, since_cmd;

   stepper_ramp_sequencer #(
      .SPEED_W(SPEED_W), .MAX_SPEED(MAXSPD), .RAMP_DIV(DIV), .RAMP_STEP(STEP),
      .SETTLE_CYCLES(SETTLE), .WATCHDOG_CYCLES(WDOG)
   ) dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_speed(cmd_speed),
      .cmd_dir(cmd_dir), .cmd_enable(cmd_enable), .estop(estop),
      .motor_speed(motor_speed), .motor_dir(motor_dir), .run_en(run_en),
      .at_target(at_target), .wdog_expired(wdog_expired), .state(state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks_total++;
      assert (observed === expected) begin
         checks_passed++;
      end else begin
         checks_failed++;
         $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, observed, expected);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_speed = 0; m_dir = 1; m_run = 0; m_at = 0; m_wexp = 0;
      t_speed = 0; t_dir = 1; t_en = 0; in_state = 0; since_cmd = 0;
   endtask

   // Advance the model by one clock using the inputs presented in that cycle.
   task automatic model_step();
      int  ns, nspd, ndir, nrun, goal;
      bit  tick, hold_done;
      if (estop) begin
         m_state = S_IDLE; m_speed = 0; m_run = 0; m_at = 0; t_en = 0;
         in_state = 0; since_cmd = 0;
         return;
      end
      m_at      = (m_state == S_RUN && m_speed == t_speed && m_dir == t_dir) ? 1 : 0;
      tick      = (m_state != S_IDLE) && ((in_state % DIV) == DIV - 1);
      hold_done = (in_state == SETTLE - 1);
      goal      = (m_state == S_RUN) ? t_speed : 0;
      nspd      = m_speed;
      if (tick) begin
         if (m_speed < goal)      nspd = (m_speed + STEP < goal) ? m_speed + STEP : goal;
         else if (m_speed > goal) nspd = (m_speed - STEP > goal) ? m_speed - STEP : goal;
      end
      ns = m_state; ndir = m_dir; nrun = m_run;
      case (m_state)
         S_IDLE:   if (t_en != 0) begin ns = S_SETTLE; ndir = t_dir; nrun = 1; end
         S_SETTLE: if (t_en == 0) ns = S_STOP; else if (hold_done) ns = S_RUN;
         S_RUN: begin
            if (t_en == 0) ns = S_STOP;
            else if (t_dir != m_dir) begin
               if (m_speed > 0) ns = S_DECEL;
               else begin ns = S_HOLD; nspd = 0; end
            end
         end
         S_DECEL: begin
            if (t_en == 0) ns = S_STOP;
            else if (t_dir == m_dir) ns = S_RUN;
            else if (m_speed == 0) ns = S_HOLD;
         end
         S_HOLD: begin
            nspd = 0;
            if (t_en == 0) ns = S_STOP;
            else if (hold_done) begin ns = S_RUN; ndir = t_dir; end
         end
         S_STOP: begin
            if (t_en != 0) ns = S_RUN;
            else if (m_speed == 0) begin ns = S_IDLE; nrun = 0; end
         end
         default: ns = S_IDLE;
      endcase
      if (m_state == S_IDLE) nspd = 0;
      if (cmd_valid) begin
         t_speed = (int'(cmd_speed) > MAXSPD) ? MAXSPD : int'(cmd_speed);
         t_dir = int'(cmd_dir); t_en = int'(cmd_enable);
         since_cmd = 0; m_wexp = 0;
      end else if (m_state == S_IDLE) begin
         since_cmd = 0;
      end else begin
         since_cmd++;
         if (since_cmd == WDOG) begin m_wexp = 1; t_en = 0; since_cmd = 0; end
      end
      in_state = (ns != m_state) ? 0 : in_state + 1;
      m_state = ns; m_speed = nspd; m_dir = ndir; m_run = nrun;
   endtask

   task automatic compare_all();
      check("speed",     32'(motor_speed),  32'(m_speed));
      check("dir",       32'(motor_dir),    32'(m_dir));
      check("run_en",    32'(run_en),       32'(m_run));
      check("at_target", 32'(at_target),    32'(m_at));
      check("wdog",      32'(wdog_expired), 32'(m_wexp));
      check("state",     32'(state),        32'(m_state));
   endtask

   task automatic step();
      @(posedge clock);
      if (reset_n) model_step(); else model_reset();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input int spd, input bit dir, input bit en);
      cmd_valid = 1'b1; cmd_speed = SPEED_W'(spd); cmd_dir = dir; cmd_enable = en;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_speed"}, 32'(motor_speed), 32'd0);
      check({tag, "_dir"},   32'(motor_dir),   32'd1);
      check({tag, "_run"},   32'(run_en),      32'd0);
      check({tag, "_at"},    32'(at_target),   32'd0);
      check({tag, "_wdog"},  32'(wdog_expired), 32'd0);
      check({tag, "_state"}, 32'(state),       32'd0);
   endtask

   initial begin
      int n_seen, min_seen;
      bit found;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_speed = '0; cmd_dir = 1'b0;
      cmd_enable = 1'b0; estop = 1'b0;
      model_reset();
      run(2);
      reset_n = 1'b1;
      check_reset_values("reset");

      // 1: settle then ramp 50/100/150/200
      send(200, 1'b1, 1'b1);
      n_seen = 0;
      for (int i = 0; i < 29; i++) begin
         step();
         if (state == 3'd1 && run_en && motor_speed == 10'd0) n_seen++;
      end
      check("settle_len", 32'(n_seen), 32'd8);
      check("s1_speed", 32'(motor_speed), 32'd200);
      check("s1_at_target", 32'(at_target), 32'd1);

      // 2: reversal with hold at zero
      send(200, 1'b0, 1'b1);
      n_seen = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (state == 3'd4 && motor_speed == 10'd0) n_seen++;
      end
      check("hold_len", 32'(n_seen), 32'd8);
      check("s2_dir", 32'(motor_dir), 32'd0);
      check("s2_speed", 32'(motor_speed), 32'd200);

      // 3: clamp, then ramp down without undershoot
      send(1000, 1'b0, 1'b1);
      run(25);
      check("clamp", 32'(motor_speed), 32'd400);
      send(30, 1'b0, 1'b1);
      min_seen = 1023;
      for (int i = 0; i < 40; i++) begin
         step();
         if (int'(motor_speed) < min_seen) min_seen = int'(motor_speed);
      end
      check("no_undershoot", 32'(min_seen), 32'd30);

      // 4: stop to idle, then resume from mid-ramp
      send(300, 1'b0, 1'b1);
      run(30);
      check("s4_speed", 32'(motor_speed), 32'd300);
      send(300, 1'b0, 1'b0);
      run(40);
      check("stop_idle", 32'(state), 32'd0);
      check("stop_run_en", 32'(run_en), 32'd0);
      send(300, 1'b0, 1'b1);
      run(40);
      send(300, 1'b0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (motor_speed == 10'd150) found = 1'b1;
      end
      check("reach_150", 32'(found), 32'd1);
      send(300, 1'b0, 1'b1);
      min_seen = 1023;
      for (int i = 0; i < 30; i++) begin
         step();
         if (int'(motor_speed) < min_seen) min_seen = int'(motor_speed);
      end
      check("resume_min", 32'(min_seen), 32'd150);
      check("resume_state", 32'(state), 32'd2);

      // 5: watchdog
      run(2100);
      check("wdog_set", 32'(wdog_expired), 32'd1);
      check("wdog_idle", 32'(state), 32'd0);
      send(250, 1'b1, 1'b1);
      check("wdog_clear", 32'(wdog_expired), 32'd0);

      // 6: estop, then async reset mid-ramp
      run(35);
      check("s6_speed", 32'(motor_speed), 32'd250);
      estop = 1'b1;
      step();
      estop = 1'b0;
      check("estop_speed", 32'(motor_speed), 32'd0);
      check("estop_run", 32'(run_en), 32'd0);
      check("estop_state", 32'(state), 32'd0);
      run(5);
      send(250, 1'b1, 1'b1);
      run(18);
      #2 reset_n = 1'b0;
      #1;
      check_reset_values("async");
      model_reset();
      run(2);
      reset_n = 1'b1;
      run(3);

      // randomized commands, reversals and estops
      for (int i = 0; i < 4000; i++) begin
         cmd_valid  = ($urandom_range(0, 29) == 0);
         cmd_speed  = SPEED_W'($urandom_range(0, 1023));
         cmd_dir    = 1'($urandom_range(0, 1));
         cmd_enable = ($urandom_range(0, 9) != 0);
         estop      = ($urandom_range(0, 399) == 0);
         step();
      end
      cmd_valid = 1'b0; estop = 1'b0;
      run(4);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
